// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: assembles big-endian 32-bit words,
// writes them to consecutive word addresses, then raises start_o for the CPU.
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  input  logic              last_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              start_o,
  output logic [8:0]        word_count_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic [8:0]        word_count_q, word_count_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic              accept;
  logic              mem_full;

  assign accept   = byte_valid_i && byte_ready_o;
  assign mem_full = (32'(word_count_q) >= 32'(DEPTH));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      byte_cnt_q   <= 2'd0;
      word_q       <= 32'd0;
      last_q       <= 1'b0;
      word_count_q <= 9'd0;
      mem_addr_q   <= '0;
      mem_data_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      last_q       <= last_d;
      word_count_q <= word_count_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    last_d       = last_q;
    word_count_d = word_count_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          word_d     = {byte_data_i, 24'h000000};
          byte_cnt_d = 2'd1;
          state_d    = last_i ? ERR : COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd1:    word_d[23:16] = byte_data_i;
            2'd2:    word_d[15:8]  = byte_data_i;
            default: word_d[7:0]   = byte_data_i;
          endcase
          if (byte_cnt_q == 2'd3) begin
            // Address and data are latched here so they hold after the strobe.
            if (mem_full) begin
              state_d = ERR;
            end else begin
              state_d    = WRITE;
              last_d     = last_i;
              mem_addr_d = ADDR_W'({word_count_q, 2'b00});
              mem_data_d = {word_q[31:8], byte_data_i};
            end
          end else if (last_i) begin
            state_d = ERR;
          end
        end
      end
      WRITE: begin
        word_count_d = mem_full ? word_count_q : word_count_q + 9'd1;
        byte_cnt_d   = 2'd0;
        state_d      = last_q ? DONE : IDLE;
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_ready_o = (state_q == IDLE) || (state_q == COLLECT);
    mem_we_o     = (state_q == WRITE);
    start_o      = (state_q == DONE);
    err_o        = (state_q == ERR);
  end

  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-depth instance and a DEPTH=4
// instance share one byte stream so overflow can be exercised alongside.
module tb_imem_loader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;
  logic        last_i = 1'b0;

  logic        ready_b, we_b, start_b, err_b;
  logic [31:0] addr_b, data_b;
  logic [8:0]  wc_b;
  logic        ready_s, we_s, start_s, err_s;
  logic [31:0] addr_s, data_s;
  logic [8:0]  wc_s;

  int errors = 0;
  int checks = 0;

  logic [31:0] wr_addr_b[$];
  logic [31:0] wr_data_b[$];
  logic [31:0] wr_addr_s[$];
  int          rdy_viol = 0;
  bit          mon_en = 1'b0;

  always #5 clk_i = ~clk_i;

  imem_loader u_big (
    .clk_i(clk_i), .rst_i(rst_i), .byte_valid_i(byte_valid_i),
    .byte_data_i(byte_data_i), .last_i(last_i), .byte_ready_o(ready_b),
    .mem_we_o(we_b), .mem_addr_o(addr_b), .mem_data_o(data_b),
    .start_o(start_b), .word_count_o(wc_b), .err_o(err_b)
  );

  imem_loader #(.DEPTH(4), .ADDR_W(32)) u_small (
    .clk_i(clk_i), .rst_i(rst_i), .byte_valid_i(byte_valid_i),
    .byte_data_i(byte_data_i), .last_i(last_i), .byte_ready_o(ready_s),
    .mem_we_o(we_s), .mem_addr_o(addr_s), .mem_data_o(data_s),
    .start_o(start_s), .word_count_o(wc_s), .err_o(err_s)
  );

  // Records every write strobe and flags any loading cycle where ready is not !we.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (we_b) begin
        wr_addr_b.push_back(addr_b);
        wr_data_b.push_back(data_b);
      end
      if (we_s) wr_addr_s.push_back(addr_s);
      if (!start_b && !err_b && (ready_b == we_b)) rdy_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    byte_valid_i = 1'b0;
    last_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic mon_start();
    wr_addr_b.delete();
    wr_data_b.delete();
    wr_addr_s.delete();
    rdy_viol = 0;
    mon_en = 1'b1;
  endtask

  // Presents one byte at posedge+1 and returns at posedge+1 after it is accepted.
  task automatic send(input logic [7:0] b, input logic l);
    int guard = 0;
    byte_valid_i = 1'b1;
    byte_data_i = b;
    last_i = l;
    while (!ready_b && guard < 20) begin
      @(posedge clk_i); #1;
      guard++;
    end
    chk("send_ready", {31'b0, ready_b}, 32'd1);
    @(posedge clk_i); #1;
    byte_valid_i = 1'b0;
    last_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic l, input bit gaps);
    int n;
    for (int k = 0; k < 4; k++) begin
      if (gaps) begin
        n = $urandom_range(1, 3);
        repeat (n) begin @(posedge clk_i); #1; end
      end
      send(w[31-8*k -: 8], l && (k == 3));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] words [3];
    words[0] = 32'h11223344;
    words[1] = 32'h55667788;
    words[2] = 32'h99AABBCC;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("rst_ready", {31'b0, ready_b}, 32'd1);
    chk("rst_we", {31'b0, we_b}, 32'd0);
    chk("rst_addr", addr_b, 32'd0);
    chk("rst_data", data_b, 32'd0);
    chk("rst_start", {31'b0, start_b}, 32'd0);
    chk("rst_err", {31'b0, err_b}, 32'd0);
    chk("rst_wc", {23'b0, wc_b}, 32'd0);

    // Single word with last: write one cycle after the 4th byte, then start
    send(8'h8C, 1'b0);
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b1);
    chk("w1_we", {31'b0, we_b}, 32'd1);
    chk("w1_addr", addr_b, 32'd0);
    chk("w1_data", data_b, 32'h8C010000);
    chk("w1_ready_wr", {31'b0, ready_b}, 32'd0);
    chk("w1_start_wr", {31'b0, start_b}, 32'd0);
    @(posedge clk_i); #1;
    chk("w1_we_after", {31'b0, we_b}, 32'd0);
    chk("w1_start", {31'b0, start_b}, 32'd1);
    chk("w1_wc", {23'b0, wc_b}, 32'd1);
    chk("w1_ready_done", {31'b0, ready_b}, 32'd0);
    // Bytes offered in DONE are ignored
    byte_valid_i = 1'b1;
    byte_data_i = 8'hFF;
    repeat (4) begin @(posedge clk_i); #1; end
    byte_valid_i = 1'b0;
    chk("done_ign_wc", {23'b0, wc_b}, 32'd1);
    chk("done_ign_data", data_b, 32'h8C010000);
    chk("done_ign_start", {31'b0, start_b}, 32'd1);

    // Three words back-to-back
    do_reset();
    mon_start();
    for (int w = 0; w < 3; w++) send_word(words[w], w == 2, 1'b0);
    @(posedge clk_i); #1;
    mon_en = 1'b0;
    chk("b2b_nwr", 32'(wr_addr_b.size()), 32'd3);
    for (int w = 0; w < 3; w++) begin
      chk("b2b_addr", wr_addr_b[w], 32'(w * 4));
      chk("b2b_data", wr_data_b[w], words[w]);
    end
    chk("b2b_ready_viol", 32'(rdy_viol), 32'd0);
    chk("b2b_wc", {23'b0, wc_b}, 32'd3);
    chk("b2b_start", {31'b0, start_b}, 32'd1);

    // last_i on the 2nd byte of a word
    do_reset();
    mon_start();
    send(8'hA0, 1'b0);
    send(8'hB1, 1'b1);
    repeat (2) begin @(posedge clk_i); #1; end
    mon_en = 1'b0;
    chk("part_err", {31'b0, err_b}, 32'd1);
    chk("part_start", {31'b0, start_b}, 32'd0);
    chk("part_nwr", 32'(wr_addr_b.size()), 32'd0);
    chk("part_ready", {31'b0, ready_b}, 32'd0);
    chk("part_wc", {23'b0, wc_b}, 32'd0);

    // Overflow on the DEPTH=4 instance
    do_reset();
    mon_start();
    for (int w = 0; w < 5; w++) send_word(32'hC0DE0000 + 32'(w), 1'b0, 1'b0);
    @(posedge clk_i); #1;
    mon_en = 1'b0;
    chk("ovf_nwr", 32'(wr_addr_s.size()), 32'd4);
    for (int w = 0; w < 4; w++) chk("ovf_addr", wr_addr_s[w], 32'(w * 4));
    chk("ovf_err", {31'b0, err_s}, 32'd1);
    chk("ovf_wc", {23'b0, wc_s}, 32'd4);
    chk("ovf_start", {31'b0, start_s}, 32'd0);
    chk("ovf_hold_addr", addr_s, 32'd12);
    chk("ovf_big_wc", {23'b0, wc_b}, 32'd5);
    chk("ovf_big_err", {31'b0, err_b}, 32'd0);

    // Asynchronous reset mid-word discards the partial word
    do_reset();
    mon_start();
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    rst_i = 1'b1;
    #1;
    chk("arst_ready", {31'b0, ready_b}, 32'd1);
    chk("arst_we", {31'b0, we_b}, 32'd0);
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;
    send_word(32'h00000020, 1'b1, 1'b0);
    chk("arst_we_wr", {31'b0, we_b}, 32'd1);
    chk("arst_addr", addr_b, 32'd0);
    chk("arst_data", data_b, 32'h00000020);
    @(posedge clk_i); #1;
    mon_en = 1'b0;
    chk("arst_start", {31'b0, start_b}, 32'd1);
    chk("arst_wc", {23'b0, wc_b}, 32'd1);
    chk("arst_nwr", 32'(wr_addr_b.size()), 32'd1);

    // Reset during WRITE kills the strobe at once
    do_reset();
    send_word(32'hCAFEF00D, 1'b0, 1'b0);
    chk("wrst_we_pre", {31'b0, we_b}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("wrst_we", {31'b0, we_b}, 32'd0);
    chk("wrst_addr", addr_b, 32'd0);
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("wrst_wc", {23'b0, wc_b}, 32'd0);

    // Same three words with random gaps between bytes
    do_reset();
    mon_start();
    for (int w = 0; w < 3; w++) send_word(words[w], w == 2, 1'b1);
    @(posedge clk_i); #1;
    mon_en = 1'b0;
    chk("gap_nwr", 32'(wr_addr_b.size()), 32'd3);
    for (int w = 0; w < 3; w++) begin
      chk("gap_addr", wr_addr_b[w], 32'(w * 4));
      chk("gap_data", wr_data_b[w], words[w]);
    end
    chk("gap_wc", {23'b0, wc_b}, 32'd3);
    chk("gap_start", {31'b0, start_b}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 256, instruction-memory capacity in 32-bit words.
REQ-002 Parameter ADDR_W, default 32, width of mem_addr_o (byte address).
REQ-003 clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 byte_valid_i  input  1  byte_data_i/last_i valid this cycle.
REQ-006 byte_data_i  input  8  program byte, big-endian order (instruction MSB first).
REQ-007 last_i  input  1  qualifies the final byte of the program image.
REQ-008 byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-009 mem_we_o  output  1  one-cycle instruction-memory write strobe.
REQ-010 mem_addr_o  output  ADDR_W  word-aligned byte address of the write (word_index*4).
REQ-011 mem_data_o  output  32  assembled instruction word.
REQ-012 start_o  output  1  drives CPU start_i; high once the image is loaded.
REQ-013 word_count_o  output  9  number of words written so far.
REQ-014 err_o  output  1  sticky load-error flag.

Function
REQ-015 Byte transfer SHALL occur only when byte_valid_i and byte_ready_o are both high on a rising edge.
REQ-016 FSM states SHALL be IDLE, COLLECT, WRITE, DONE, ERR.
REQ-017 IDLE: byte_ready_o=1; an accepted byte goes to bits [31:24], byte counter=1, move to COLLECT.
REQ-018 COLLECT: byte_ready_o=1; accepted bytes fill [23:16], [15:8], [7:0] in order; the 4th byte moves to WRITE.
REQ-019 WRITE: single cycle; mem_we_o=1, mem_addr_o=word_count_o*4, mem_data_o=assembled word; byte_ready_o=0; word_count_o increments at cycle end.
REQ-020 After WRITE: if last_i was accepted with the 4th byte, go to DONE; otherwise go to IDLE.
REQ-021 Load latency: mem_we_o SHALL assert the cycle after the 4th byte is accepted.
REQ-022 last_i accepted with byte 1, 2 or 3 of a word (partial word): no write, go to ERR.
REQ-023 4th byte accepted when word_count_o==DEPTH (overflow): no write, go to ERR.
REQ-024 Zero-length image (last_i never asserted): loader SHALL wait in IDLE/COLLECT indefinitely; start_o stays 0.
REQ-025 DONE: start_o=1 held until reset; byte_ready_o=0; further bytes are ignored; mem_we_o=0.
REQ-026 ERR: err_o=1 sticky, start_o=0, byte_ready_o=0, mem_we_o=0 until reset.
REQ-027 mem_we_o SHALL never be high outside WRITE; mem_addr_o/mem_data_o hold their last value otherwise.
REQ-028 byte_valid_i with byte_ready_o=0 SHALL have no effect (byte not consumed, not buffered).
REQ-029 word_count_o SHALL saturate at DEPTH; it never wraps.

Reset
REQ-030 rst_i high SHALL immediately force IDLE, byte counter=0, word_count_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, start_o=0, err_o=0, byte_ready_o=1 after release.
REQ-031 Reset asserted mid-word or during WRITE SHALL discard the partial word; no write strobe occurs in the reset cycle.
REQ-032 After reset release, loading SHALL restart at address 0.

Verification
REQ-033 Bytes 8C,01,00,00 with last_i on 4th -> one cycle later mem_we_o=1, addr=0, data=32'h8C010000; next cycle start_o=1, word_count_o=1.
REQ-034 Three words back-to-back, byte_valid_i held high -> writes at addr 0,4,8; byte_ready_o low exactly in each WRITE cycle; word_count_o=3; start_o=1.
REQ-035 last_i on 2nd byte of a word -> err_o=1, no mem_we_o pulse for that word, start_o=0.
REQ-036 DEPTH=4, 5 full words -> four writes (addr 0..12), 5th word gives err_o=1, word_count_o=4.
REQ-037 rst_i pulsed after 2 bytes of word 1 -> no write; then full word 00000020 with last_i -> written at addr 0, start_o=1.
REQ-038 Bytes with gaps (byte_valid_i low 1-3 random cycles between bytes) -> identical words and addresses as gap-free stimulus.
